// File: rtl/fpu_add_pkg.sv
// fpu_add_pkg: single-precision field layout and shared helpers for the add-share block.
// Rev 1.0
`default_nettype none

package fpu_add_pkg;
   localparam int FP_W       = 32;
   localparam int EXPO_W     = 8;
   localparam int SIGNIF_W   = 23;
   localparam int SIGNIF_LSB = 0;
   localparam int EXPO_LSB   = SIGNIF_W;
   localparam int SIGN_POS   = FP_W - 1;

   // All-ones exponent with a non-zero significand.
   function automatic logic is_nan(input logic [FP_W-1:0] word);
      return (&word[EXPO_LSB +: EXPO_W]) && (|word[SIGNIF_LSB +: SIGNIF_W]);
   endfunction

   function automatic logic [31:0] rr_next(input logic [31:0] ptr, input logic [31:0] n);
      return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
   endfunction
endpackage

`default_nettype wire

// File: rtl/fpadd_rr_arbiter.sv
// fpadd_rr_arbiter: N_REQ-way round-robin grant with its own rotating pointer.
// Rev 1.0
`default_nettype none

module fpadd_rr_arbiter
   import fpu_add_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_hold,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_grant_id,
   output logic             o_grant_vld
);

   logic [ID_W-1:0] r_ptr;
   logic [ID_W-1:0] w_cand;
   logic [ID_W-1:0] w_id;

   // Scan from the far end back toward the pointer so the nearest valid lane wins.
   always_comb begin
      w_id   = '0;
      w_cand = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
         if (i_req[w_cand]) begin
            w_id = w_cand;
         end
      end
   end

   assign o_grant_vld = (|i_req) & ~i_hold;
   assign o_grant_id  = w_id;
   assign o_grant     = o_grant_vld ? (N_REQ'(1) << w_id) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (o_grant_vld) begin
         r_ptr <= ID_W'(rr_next(32'(w_id), 32'(N_REQ)));
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpadd_share_arbiter.sv
// fpadd_share_arbiter: round-robin sharing of one combinational FP add/sub among N_REQ lanes.
// Rev 1.0
`default_nettype none

module fpadd_share_arbiter
   import fpu_add_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int EXTRA_STAGES = 0,
   parameter int CNT_W        = 16,
   localparam int ID_W        = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [FP_W*N_REQ-1:0] req_a,
   input  logic [FP_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]      req_sub,
   input  logic                  hold,
   output logic [FP_W-1:0]       add_a,
   output logic [FP_W-1:0]       add_b,
   output logic                  add_sub,
   input  logic [FP_W-1:0]       add_c,
   output logic                  resp_valid,
   output logic [ID_W-1:0]       resp_id,
   output logic [FP_W-1:0]       resp_data,
   output logic                  busy,
   input  logic                  nan_clr,
   output logic [CNT_W-1:0]      nan_count
);

   logic [ID_W-1:0]   w_gid;
   logic              w_gnt_vld;
   logic              w_nan_hit;

   logic              r_s0_valid;
   logic [ID_W-1:0]   r_s0_id;
   logic [FP_W-1:0]   r_add_a;
   logic [FP_W-1:0]   r_add_b;
   logic              r_add_sub;

   // Index 0 is the result register right after the datapath; the last index feeds resp_*.
   logic [EXTRA_STAGES:0] r_pv;
   logic [ID_W-1:0]       r_pid [EXTRA_STAGES+1];
   logic [FP_W-1:0]       r_pd  [EXTRA_STAGES+1];

   logic [CNT_W-1:0]  r_nan_cnt;

   fpadd_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req_valid),
      .i_hold      (hold),
      .o_grant     (req_ready),
      .o_grant_id  (w_gid),
      .o_grant_vld (w_gnt_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_valid <= 1'b0;
         r_s0_id    <= '0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_add_sub  <= 1'b0;
         r_pv       <= '0;
         for (int s = 0; s <= EXTRA_STAGES; s++) begin
            r_pid[s] <= '0;
            r_pd[s]  <= '0;
         end
      end else if (!hold) begin
         r_s0_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_s0_id   <= w_gid;
            r_add_a   <= req_a[FP_W*w_gid +: FP_W];
            r_add_b   <= req_b[FP_W*w_gid +: FP_W];
            r_add_sub <= req_sub[w_gid];
         end
         r_pv[0]  <= r_s0_valid;
         r_pid[0] <= r_s0_id;
         r_pd[0]  <= add_c;
         for (int s = 1; s <= EXTRA_STAGES; s++) begin
            r_pv[s]  <= r_pv[s-1];
            r_pid[s] <= r_pid[s-1];
            r_pd[s]  <= r_pd[s-1];
         end
      end
   end

   assign add_a      = r_add_a;
   assign add_b      = r_add_b;
   assign add_sub    = r_add_sub;

   // A held result stays in the last stage and is shown once hold drops.
   assign resp_valid = r_pv[EXTRA_STAGES] & ~hold;
   assign resp_id    = r_pid[EXTRA_STAGES];
   assign resp_data  = r_pd[EXTRA_STAGES];
   assign busy       = r_s0_valid | (|r_pv);

   assign w_nan_hit  = resp_valid & is_nan(resp_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nan_cnt <= '0;
      end else if (nan_clr) begin
         r_nan_cnt <= '0;
      end else if (w_nan_hit && !(&r_nan_cnt)) begin
         r_nan_cnt <= r_nan_cnt + CNT_W'(1);
      end
   end

   assign nan_count = r_nan_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fpadd_share_arbiter.sv
// tb_fpadd_share_arbiter: scoreboard bench with a real-arithmetic datapath model and RR model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fpadd_share_arbiter;
   localparam int N   = 4;
   localparam int XS  = 0;
   localparam int IDW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready, req_ready2;
   logic [32*N-1:0] req_a = '0;
   logic [32*N-1:0] req_b = '0;
   logic [N-1:0]    req_sub = '0;
   logic            hold = 1'b0;
   logic            nan_clr = 1'b0;
   logic [31:0]     add_a, add_b, add_c, add_a2, add_b2, add_c2;
   logic            add_sub, add_sub2;
   logic            resp_valid, resp_valid2, busy, busy2;
   logic [IDW-1:0]  resp_id, resp_id2;
   logic [31:0]     resp_data, resp_data2;
   logic [15:0]     nan_count;
   logic [1:0]      nan_count2;

   always #5 clk = ~clk;

   function automatic logic tb_is_nan(input logic [31:0] w);
      return (w[30:23] == 8'hFF) && (w[22:0] != 23'h0);
   endfunction

   function automatic real fp_to_real(input logic [31:0] w);
      real m;
      int  e;
      e = int'(w[30:23]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return w[31] ? -m : m;
   endfunction

   function automatic logic [31:0] real_to_fp(input real r);
      real  m;
      int   e;
      logic s;
      logic [22:0] f;
      if (r == 0.0) return 32'h0;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      if (e + 127 >= 255) return {s, 8'hFF, 23'h0};
      if (e + 127 <= 0)   return {s, 31'h0};
      f = 23'($rtoi((m - 1.0) * 8388608.0));
      return {s, 8'(e + 127), f};
   endfunction

   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      if (tb_is_nan(a) || tb_is_nan(b)) return 32'h7FC00000;
      return real_to_fp(sub ? (fp_to_real(a) - fp_to_real(b)) : (fp_to_real(a) + fp_to_real(b)));
   endfunction

   assign add_c  = fp_model(add_a, add_b, add_sub);
   assign add_c2 = fp_model(add_a2, add_b2, add_sub2);

   fpadd_share_arbiter #(.N_REQ(N), .EXTRA_STAGES(XS), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .hold(hold),
      .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_c(add_c),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .busy(busy), .nan_clr(nan_clr), .nan_count(nan_count)
   );

   fpadd_share_arbiter #(.N_REQ(N), .EXTRA_STAGES(XS), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .hold(hold),
      .add_a(add_a2), .add_b(add_b2), .add_sub(add_sub2), .add_c(add_c2),
      .resp_valid(resp_valid2), .resp_id(resp_id2), .resp_data(resp_data2),
      .busy(busy2), .nan_clr(nan_clr), .nan_count(nan_count2)
   );

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      int             due;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          failures = 0;
   int          act = 0;
   int          mptr = 0;
   int          last_g = -1;
   logic [N-1:0] lv = '0;
   logic [31:0] la [N];
   logic [31:0] lb [N];
   logic        ls [N];

   // Counts cycles in which the pipeline is allowed to advance.
   always @(posedge clk) if (!hold) act <= act + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step(input logic h, input logic clr);
      int   g;
      exp_t e;
      logic [N-1:0] expg;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = la[i];
         req_b[32*i +: 32] = lb[i];
         req_sub[i]        = ls[i];
      end
      req_valid = lv;
      hold      = h;
      nan_clr   = clr;
      #1;
      g = -1;
      if (!h) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && lv[(mptr + k) % N]) g = (mptr + k) % N;
         end
      end
      expg = '0;
      if (g >= 0) expg[g] = 1'b1;
      chk("grant", 32'(req_ready), 32'(expg));
      if (g >= 0) begin
         e.id   = IDW'(g);
         e.data = fp_model(la[g], lb[g], ls[g]);
         e.due  = act + 2 + XS;
         sbq.push_back(e);
         mptr = (g + 1) % N;
      end
      last_g = g;
   endtask

   task automatic drain();
      lv = '0;
      for (int i = 0; i < 20 && (sbq.size() > 0 || busy); i++) step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      checks++;
      if (sbq.size() > 0) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d want=0", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      la[i] = a; lb[i] = b; ls[i] = s;
   endtask

   function automatic logic [31:0] rnd_fp();
      if ($urandom_range(9) == 0) return 32'h7FC00000 | 32'($urandom_range(255));
      return {1'($urandom_range(1)), 8'($urandom_range(134, 120)), 23'($urandom)};
   endfunction

   // Response monitor and NaN-counter model.
   int mcnt = 0;
   int mcnt2 = 0;
   initial begin
      exp_t e;
      logic hit;
      forever begin
         @(negedge clk);
         hit = 1'b0;
         if (!rst_n) begin
            mcnt  = 0;
            mcnt2 = 0;
         end
         chk("nan_count", 32'(nan_count), 32'(mcnt));
         chk("nan_count_sat", 32'(nan_count2), 32'(mcnt2));
         if (!rst_n || hold) begin
            chk("resp_valid_quiet", 32'(resp_valid), 32'd0);
         end else if (resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: id=%0d data=%h want=none", resp_id, resp_data);
            end else begin
               e = sbq.pop_front();
               chk("resp_id", 32'(resp_id), 32'(e.id));
               chk("resp_data", resp_data, e.data);
               chk("resp_latency", 32'(act), 32'(e.due));
               hit = tb_is_nan(e.data);
            end
         end else if (sbq.size() > 0 && sbq[0].due <= act) begin
            e = sbq.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_resp: resp_valid=0 want id=%0d data=%h", e.id, e.data);
         end
         if (rst_n) begin
            if (nan_clr) begin
               mcnt  = 0;
               mcnt2 = 0;
            end else if (hit) begin
               if (mcnt < 65535) mcnt++;
               if (mcnt2 < 3) mcnt2++;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) set_lane(i, 32'h0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #3;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_nan", 32'(nan_count), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single request on lane 2: 1.0 + 1.0.
      set_lane(2, 32'h3F800000, 32'h3F800000, 1'b0);
      lv = 4'b0100;
      step(1'b0, 1'b0);
      chk("single_ready", 32'(req_ready), 32'h4);
      chk("single_data_model", fp_model(la[2], lb[2], ls[2]), 32'h40000000);
      lv = 4'b1000;
      step(1'b0, 1'b0);
      drain();

      // All lanes valid for 8 cycles from pointer 0.
      for (int i = 0; i < N; i++) set_lane(i, 32'h3F800000 + 32'(i << 20), 32'h3F800000, 1'b0);
      set_lane(1, 32'h40400000, 32'h3F800000, 1'b1);
      lv = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0);
         chk("rr_order", 32'(req_ready), 32'(1) << (k % 4));
      end
      drain();

      // Lanes 1 and 3 with pointer at 2.
      lv = 4'b0010;
      step(1'b0, 1'b0);
      lv = 4'b1010;
      step(1'b0, 1'b0);
      chk("ptr2_first", 32'(req_ready), 32'h8);
      lv = 4'b0010;
      step(1'b0, 1'b0);
      chk("ptr2_second", 32'(req_ready), 32'h2);
      lv = 4'b1110;
      step(1'b0, 1'b0);
      chk("ptr_end", 32'(req_ready), 32'h4);
      drain();

      // Hold for 3 cycles starting one cycle after an accept.
      lv = 4'b0001;
      step(1'b0, 1'b0);
      lv = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0);
         chk("hold_busy", 32'(busy), 32'd1);
      end
      lv = '0;
      step(1'b0, 1'b0);
      chk("hold_busy_after", 32'(busy), 32'd1);
      drain();

      // NaN counting, clear-wins, and saturation of the narrow counter.
      step(1'b0, 1'b1);
      set_lane(0, 32'h7FC00000, 32'h3F800000, 1'b0);
      lv = 4'b0001;
      repeat (3) step(1'b0, 1'b0);
      drain();
      chk("nan_three", 32'(nan_count), 32'd3);
      lv = 4'b0001;
      step(1'b0, 1'b0);
      lv = '0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain();
      chk("nan_clr_wins", 32'(nan_count), 32'd0);
      lv = 4'b0001;
      repeat (5) step(1'b0, 1'b0);
      drain();
      chk("nan_five", 32'(nan_count), 32'd5);
      chk("nan_sat", 32'(nan_count2), 32'd3);

      // Asynchronous reset with two operations in flight.
      for (int i = 0; i < N; i++) set_lane(i, 32'h40400000, 32'h3F800000, 1'b0);
      lv = 4'b0011;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      lv = '0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req_valid = '0;
      sbq.delete();
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_resp_valid", 32'(resp_valid), 32'd0);
      chk("arst_add_a", add_a, 32'd0);
      chk("arst_add_sub", 32'(add_sub), 32'd0);
      chk("arst_nan", 32'(nan_count), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      mptr = 0;
      repeat (3) step(1'b0, 1'b0);
      lv = 4'b1011;
      step(1'b0, 1'b0);
      chk("post_rst_lane0", 32'(req_ready), 32'h1);
      drain();

      // Randomized traffic with holds, drops and clears.
      for (int i = 0; i < N; i++) set_lane(i, rnd_fp(), rnd_fp(), 1'($urandom_range(1)));
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(9) == 0), ($urandom_range(32) == 0));
         for (int i = 0; i < N; i++) begin
            if (last_g == i) lv[i] = 1'b0;
            else if (lv[i] && $urandom_range(19) == 0) lv[i] = 1'b0;
            else if (!lv[i] && $urandom_range(1) == 1) begin
               lv[i] = 1'b1;
               set_lane(i, rnd_fp(), rnd_fp(), 1'($urandom_range(1)));
            end
         end
      end
      hold = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/fpadd_share_arbiter.md
Name: fpadd_share_arbiter

Overview:
- Shares one combinational single-precision add/sub datapath among N_REQ vector-lane requesters.
- Performs round-robin arbitration and accepts at most one operation per cycle.
- Registers the operands in front of the datapath and delays the requester tag through a fixed-depth pipeline.
- Returns each tagged result on a shared response bus, keeps a saturating NaN-result counter, and supports a global hold (stall) from the vector unit.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- EXTRA_STAGES, 0: extra result register stages after the datapath for retiming (0..3).
- CNT_W, 16: NaN counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  32*N_REQ  operand A, packed; lane i is bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, packed.
- req_sub  in  N_REQ  1 = A-B, 0 = A+B.
- hold  in  1  freeze the whole block.
- add_a  out  32  registered operand A to the datapath.
- add_b  out  32  registered operand B to the datapath.
- add_sub  out  1  registered subtract select.
- add_c  in  32  combinational datapath result.
- resp_valid  out  1  one-cycle result strobe.
- resp_id  out  clog2(N_REQ)  requester index of the result.
- resp_data  out  32  result.
- busy  out  1  any pipeline stage valid.
- nan_clr  in  1  synchronous clear of nan_count.
- nan_count  out  CNT_W  saturating count of NaN results.

Behaviour:
- Reset values: all registers 0, including req_ready, add_a, add_b, add_sub, resp_*, busy, nan_count. The round-robin pointer resets to 0.
- Arbitration:
  - Requests are searched starting at the pointer, wrapping modulo N_REQ.
  - The first requester with req_valid=1 gets req_ready=1 in the same cycle (combinational from req_valid, pointer and hold).
  - A transfer occurs when req_valid & req_ready.
- Pointer update: after a grant to index g, pointer <= (g+1) mod N_REQ. With no grant the pointer is unchanged.
- Requester rule: a requester must keep req_valid and its operands stable until accepted. Dropping valid before acceptance is allowed; the operation is simply not issued.
- Stage S0 (issue register):
  - On accept, the granted lane's req_a/req_b/req_sub load into add_a/add_b/add_sub.
  - s0_valid<=1 and s0_id<=g.
  - With no accept, s0_valid<=0; the add_* registers keep their old values.
- Stage S1 (result register): S1 <= {s0_valid, s0_id, add_c}.
- EXTRA_STAGES further shift stages follow S1. The last stage drives resp_valid, resp_id and resp_data.
- Latency: accept in cycle T gives resp_valid in cycle T+2+EXTRA_STAGES.
- Throughput: 1 operation per cycle, with no backpressure on responses. Requesters must always sink a response addressed to them.
- hold=1:
  - req_ready is forced to 0 and the pointer is held.
  - All pipeline registers hold their values, and add_* hold so add_c stays consistent.
  - resp_valid is forced to 0 during hold. A result sitting in the last stage is presented once, in the first cycle after hold falls.
- busy = OR of all stage valid bits; it is independent of hold.
- NaN counter:
  - A result counts when resp_valid=1 (not held) and resp_data[30:23]==8'hFF with resp_data[22:0]!=0.
  - nan_count increments by 1 on each counted result and saturates at all ones.
  - If nan_clr and a counted NaN occur in the same cycle, clear wins: the result is 0.
- Reset mid-operation: all in-flight operations are discarded with no response. The pointer returns to 0.

Decomposition:
- Shared package fpu_add_pkg holds:
  - FP_W=32, EXPO_W=8, SIGNIF_W=23;
  - the exponent/significand field positions;
  - function is_nan(word);
  - function rr_next(ptr, n).
- One sub-module, fpadd_rr_arbiter (N_REQ-way round-robin grant plus pointer register), is natural. The tag/result delay pipeline stays inline.

Test Plan:
- Single request, lane 2: A=0x3F800000, B=0x3F800000, sub=0, EXTRA_STAGES=0.
  -> req_ready[2] asserted in the request cycle; 2 cycles later resp_valid=1, resp_id=2, resp_data=0x40000000.
- Lanes 0..3 all valid continuously for 8 cycles, pointer starting at 0.
  -> grants are 0,1,2,3,0,1,2,3; responses arrive in the same order, back-to-back, each with the correct lane's result. Use lane 1 A=0x40400000, B=0x3F800000, sub=1 -> 0x40000000.
- Lanes 1 and 3 both valid with pointer=2.
  -> lane 3 is granted first, then lane 1, and the pointer ends at 2.
- Hold asserted for 3 cycles starting one cycle after an accept.
  -> no req_ready and no resp_valid during hold; a single response appears one cycle after hold falls, and busy stays 1 throughout.
- NaN operand A=0x7FC00000 + B=0x3F800000, issued 3 times with nan_count=0.
  -> nan_count=3. A further NaN issued while nan_clr is pulsed in the response cycle leaves nan_count=0. With CNT_W=2, five NaN results saturate nan_count at 3.
- rst_n asserted low asynchronously while 2 operations are in flight.
  -> all outputs go to 0 immediately; no response is emitted after release; the next request on lane 0 is granted first.
